matriz_carregador: RTL and testbench

Write-side counterpart of the matrix ALU operators, including the determinant units. It accepts matrix elements one at a time over a valid/ready stream and assembles them into the packed 200-bit matrix bus. It then presents the bus to the operators together with a `tamanho` code. `tamanho` is non-zero only while a complete matrix is held, so the determinant units compute only on fully loaded data.

---
 rtl/matriz_carregador_pkg.sv | 27 ++
 rtl/matriz_carregador_if.sv | 29 ++
 rtl/matriz_carregador_contador_rc.sv | 53 +++++
 rtl/matriz_carregador.sv | 96 +++++++++
 tb/tb_matriz_carregador.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matriz_carregador_pkg.sv
// Shared types, widths and the packed-layout index helper for the matrix loader.
package matriz_pkg;

    localparam int unsigned DIM_MAX  = 5;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MATRIZ_W = DIM_MAX * DIM_MAX * DATA_W;
    localparam int unsigned TAM_W    = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned OFF_W    = 8;

    localparam logic [TAM_W-1:0] TAM_MIN = 8'd2;
    localparam logic [TAM_W-1:0] TAM_MAX = 8'd5;

    typedef enum logic [1:0] {
        IDLE,
        CARREGA,
        PRONTO
    } estado_t;

    // Bit offset of element (i,j); the row stride is always DIM_MAX.
    function automatic logic [OFF_W-1:0] off(input logic [IDX_W-1:0] i,
                                             input logic [IDX_W-1:0] j);
        return OFF_W'((OFF_W'(i) * OFF_W'(DIM_MAX) + OFF_W'(j)) * OFF_W'(DATA_W));
    endfunction

endpackage

// File: rtl/matriz_carregador_if.sv
// Element stream in, packed matrix out, plus control/status of the loader.
interface matriz_carregador_if;
    import matriz_pkg::*;

    logic                start;
    logic [TAM_W-1:0]    tamanho_in;
    logic [DATA_W-1:0]   dado_in;
    logic                dado_valido;
    logic                dado_pronto;
    logic [MATRIZ_W-1:0] matriz;
    logic [TAM_W-1:0]    tamanho;
    logic                matriz_valida;
    logic                consumido;
    logic                ocupado;
    logic                erro;

    // Producer / consumer side.
    modport master (
        output start, tamanho_in, dado_in, dado_valido, consumido,
        input  dado_pronto, matriz, tamanho, matriz_valida, ocupado, erro
    );

    // Loader side.
    modport slave (
        input  start, tamanho_in, dado_in, dado_valido, consumido,
        output dado_pronto, matriz, tamanho, matriz_valida, ocupado, erro
    );

endinterface

// File: rtl/matriz_carregador_contador_rc.sv
// Row/column position counter with wrap at N-1, selectable traversal order
// and a flag marking the last of the N*N elements.
module matriz_contador_rc
    import matriz_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             avanca,
    input  logic             ordem_coluna,
    input  logic [IDX_W-1:0] n,
    output logic [IDX_W-1:0] lin,
    output logic [IDX_W-1:0] col,
    output logic             ultimo_c
);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] n_m1;

    assign n_m1     = IDX_W'(n - IDX_W'(1));
    assign ultimo_c = (cnt == CNT_W'(CNT_W'(n) * CNT_W'(n) - CNT_W'(1)));

    // Position and element count advance on each accepted beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lin <= '0;
            col <= '0;
            cnt <= '0;
        end else if (clr) begin
            lin <= '0;
            col <= '0;
            cnt <= '0;
        end else if (avanca) begin
            cnt <= CNT_W'(cnt + CNT_W'(1));
            if (ordem_coluna) begin
                if (lin == n_m1) begin
                    lin <= '0;
                    col <= IDX_W'(col + IDX_W'(1));
                end else begin
                    lin <= IDX_W'(lin + IDX_W'(1));
                end
            end else begin
                if (col == n_m1) begin
                    col <= '0;
                    lin <= IDX_W'(lin + IDX_W'(1));
                end else begin
                    col <= IDX_W'(col + IDX_W'(1));
                end
            end
        end
    end

endmodule

// File: rtl/matriz_carregador.sv
// Matrix loader: assembles a stream of elements into the packed matrix bus
// and exposes tamanho only while a complete matrix is held.
// Optional build macro MATRIZ_COLUNA_EN: elements arrive column-major.
module matriz_carregador
    import matriz_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    matriz_carregador_if.slave  bus
);

    estado_t          estado;
    logic [TAM_W-1:0] n_q;
    logic [IDX_W-1:0] lin;
    logic [IDX_W-1:0] col;
    logic             ultimo_c;
    logic             legal_c;
    logic             clr_c;
    logic             aceita_c;
    logic             ordem_coluna_c;

`ifdef MATRIZ_COLUNA_EN
    assign ordem_coluna_c = 1'b1;
`else
    assign ordem_coluna_c = 1'b0;
`endif

    assign legal_c  = (bus.tamanho_in >= TAM_MIN) && (bus.tamanho_in <= TAM_MAX);
    assign clr_c    = (estado == IDLE) && bus.start && legal_c;
    assign aceita_c = (estado == CARREGA) && bus.dado_valido && bus.dado_pronto;

    matriz_contador_rc u_contador (
        .clock        (clock),
        .reset        (reset),
        .clr          (clr_c),
        .avanca       (aceita_c),
        .ordem_coluna (ordem_coluna_c),
        .n            (n_q[IDX_W-1:0]),
        .lin          (lin),
        .col          (col),
        .ultimo_c     (ultimo_c)
    );

    // Control FSM with registered outputs; matriz is only touched on a legal
    // start (clear) or an accepted beat (element write).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado            <= IDLE;
            n_q               <= '0;
            bus.matriz        <= '0;
            bus.tamanho       <= '0;
            bus.matriz_valida <= 1'b0;
            bus.dado_pronto   <= 1'b0;
            bus.ocupado       <= 1'b0;
            bus.erro          <= 1'b0;
        end else begin
            bus.erro <= 1'b0;
            case (estado)
                IDLE: begin
                    if (bus.start) begin
                        if (legal_c) begin
                            n_q             <= bus.tamanho_in;
                            bus.matriz      <= '0;
                            bus.dado_pronto <= 1'b1;
                            bus.ocupado     <= 1'b1;
                            estado          <= CARREGA;
                        end else begin
                            bus.erro <= 1'b1;
                        end
                    end
                end
                CARREGA: begin
                    if (aceita_c) begin
                        bus.matriz[off(lin, col) +: DATA_W] <= bus.dado_in;
                        if (ultimo_c) begin
                            bus.matriz_valida <= 1'b1;
                            bus.tamanho       <= n_q;
                            bus.dado_pronto   <= 1'b0;
                            estado            <= PRONTO;
                        end
                    end
                end
                PRONTO: begin
                    if (bus.consumido) begin
                        bus.matriz_valida <= 1'b0;
                        bus.tamanho       <= '0;
                        bus.ocupado       <= 1'b0;
                        estado            <= IDLE;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matriz_carregador.sv
// Self-checking bench for matriz_carregador: table of loads compared against
// a packed-layout model, plus directed handshake, error and reset sequences.
module tb_matriz_carregador;
    import matriz_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    matriz_carregador_if bus();

    matriz_carregador dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [MATRIZ_W-1:0] modelo;

    typedef struct {
        int n;
        int primeiro;
        int incr;
        bit alterna;
    } carga_t;

    carga_t tabela[4];
    int     ilegais[4];

    task automatic chk(input string nome, input logic [MATRIZ_W-1:0] atual,
                       input logic [MATRIZ_W-1:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    task automatic passo;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] elem(input int i, input int j);
        return bus.matriz[8'((5 * i + j) * 8) +: 8];
    endfunction

    task automatic chk_zero(input string nome);
        chk({nome, "_matriz"}, bus.matriz, '0);
        chk({nome, "_tamanho"}, MATRIZ_W'(bus.tamanho), '0);
        chk({nome, "_valida"}, MATRIZ_W'(bus.matriz_valida), '0);
        chk({nome, "_pronto"}, MATRIZ_W'(bus.dado_pronto), '0);
        chk({nome, "_ocupado"}, MATRIZ_W'(bus.ocupado), '0);
        chk({nome, "_erro"}, MATRIZ_W'(bus.erro), '0);
    endtask

    // Start a load of n*n values primeiro + incr*k; stop after 'parar' beats
    // when parar >= 0. Builds the expected packed matrix in 'modelo'.
    task automatic carrega(input int n, input int primeiro, input int incr,
                           input bit alterna, input int parar);
        int i;
        int j;
        logic [DATA_W-1:0] v;
        modelo = '0;
        bus.start = 1'b1;
        bus.tamanho_in = 8'(n);
        passo;
        bus.start = 1'b0;
        chk("pronto_apos_start", MATRIZ_W'(bus.dado_pronto), MATRIZ_W'(1));
        for (int k = 0; k < n * n; k++) begin
            if (k == parar) break;
            if (alterna && (k % 2 == 1)) begin
                bus.dado_valido = 1'b0;
                bus.dado_in = 8'hAA;
                passo;
            end
            v = 8'(primeiro + incr * k);
`ifdef MATRIZ_COLUNA_EN
            j = k / n;
            i = k % n;
`else
            i = k / n;
            j = k % n;
`endif
            modelo[8'((5 * i + j) * 8) +: 8] = v;
            bus.dado_valido = 1'b1;
            bus.dado_in = v;
            passo;
        end
        bus.dado_valido = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.tamanho_in = '0;
        bus.dado_in = '0;
        bus.dado_valido = 1'b0;
        bus.consumido = 1'b0;

        tabela[0] = '{n: 5, primeiro: 1,   incr: 1,  alterna: 1'b0};
        tabela[1] = '{n: 3, primeiro: 1,   incr: 1,  alterna: 1'b0};
        tabela[2] = '{n: 2, primeiro: -1,  incr: -1, alterna: 1'b1};
        tabela[3] = '{n: 4, primeiro: 100, incr: -7, alterna: 1'b0};
        ilegais = '{6, 1, 0, 255};

        reset = 1'b1;
        passo;
        passo;
        chk_zero("reset");
        reset = 1'b0;
        passo;

        // Illegal sizes: one-cycle erro, block stays idle.
        foreach (ilegais[e]) begin
            bus.start = 1'b1;
            bus.tamanho_in = 8'(ilegais[e]);
            passo;
            bus.start = 1'b0;
            chk("erro_pulso", MATRIZ_W'(bus.erro), MATRIZ_W'(1));
            chk("erro_ocupado", MATRIZ_W'(bus.ocupado), '0);
            chk("erro_pronto", MATRIZ_W'(bus.dado_pronto), '0);
            passo;
            chk("erro_baixa", MATRIZ_W'(bus.erro), '0);
        end

        // Table-driven loads.
        foreach (tabela[t]) begin
            carrega(tabela[t].n, tabela[t].primeiro, tabela[t].incr, tabela[t].alterna, -1);
            chk("carga_matriz", bus.matriz, modelo);
            chk("carga_valida", MATRIZ_W'(bus.matriz_valida), MATRIZ_W'(1));
            chk("carga_tamanho", MATRIZ_W'(bus.tamanho), MATRIZ_W'(tabela[t].n));
            chk("carga_pronto", MATRIZ_W'(bus.dado_pronto), '0);
            chk("carga_ocupado", MATRIZ_W'(bus.ocupado), MATRIZ_W'(1));
            if (t == 0) begin
                chk("m5_00", MATRIZ_W'(elem(0, 0)), MATRIZ_W'(1));
                chk("m5_44", MATRIZ_W'(elem(4, 4)), MATRIZ_W'(25));
            end
            if (t == 1) begin
`ifdef MATRIZ_COLUNA_EN
                chk("m3_10", MATRIZ_W'(elem(1, 0)), MATRIZ_W'(2));
                chk("m3_20", MATRIZ_W'(elem(2, 0)), MATRIZ_W'(3));
`else
                chk("m3_10", MATRIZ_W'(elem(1, 0)), MATRIZ_W'(4));
                chk("m3_20", MATRIZ_W'(elem(2, 0)), MATRIZ_W'(7));
`endif
                chk("m3_03", MATRIZ_W'(elem(0, 3)), '0);
                chk("m3_04", MATRIZ_W'(elem(0, 4)), '0);
                chk("m3_lin3", MATRIZ_W'(bus.matriz[159:120]), '0);
            end
            if (t == 2) begin
                chk("m2_00", MATRIZ_W'(elem(0, 0)), MATRIZ_W'(8'hFF));
                chk("m2_11", MATRIZ_W'(elem(1, 1)), MATRIZ_W'(8'hFC));
                bus.dado_valido = 1'b1;
                bus.dado_in = 8'h55;
                passo;
                passo;
                bus.dado_valido = 1'b0;
                chk("pronto_ignora_dado", bus.matriz, modelo);
                chk("pronto_sem_ready", MATRIZ_W'(bus.dado_pronto), '0);
            end
            // Consume; the last entry also raises start, which must be ignored.
            bus.consumido = 1'b1;
            if (t == 3) begin
                bus.start = 1'b1;
                bus.tamanho_in = 8'd3;
            end
            passo;
            bus.consumido = 1'b0;
            bus.start = 1'b0;
            chk("consumo_valida", MATRIZ_W'(bus.matriz_valida), '0);
            chk("consumo_tamanho", MATRIZ_W'(bus.tamanho), '0);
            chk("consumo_ocupado", MATRIZ_W'(bus.ocupado), '0);
            chk("consumo_retem", bus.matriz, modelo);
            passo;
            chk("consumo_idle", MATRIZ_W'(bus.ocupado), '0);
        end

        // consumido during CARREGA has no effect.
        bus.start = 1'b1;
        bus.tamanho_in = 8'd2;
        passo;
        bus.start = 1'b0;
        bus.dado_valido = 1'b1;
        bus.dado_in = 8'd9;
        passo;
        bus.dado_valido = 1'b0;
        bus.consumido = 1'b1;
        passo;
        bus.consumido = 1'b0;
        chk("cons_carrega_ocupado", MATRIZ_W'(bus.ocupado), MATRIZ_W'(1));
        chk("cons_carrega_pronto", MATRIZ_W'(bus.dado_pronto), MATRIZ_W'(1));
        chk("cons_carrega_valida", MATRIZ_W'(bus.matriz_valida), '0);
        for (int k = 8; k >= 6; k--) begin
            bus.dado_valido = 1'b1;
            bus.dado_in = 8'(k);
            passo;
        end
        bus.dado_valido = 1'b0;
        chk("cons_carrega_fim", MATRIZ_W'(bus.matriz_valida), MATRIZ_W'(1));
        chk("cons_carrega_tam", MATRIZ_W'(bus.tamanho), MATRIZ_W'(2));
        chk("cons_carrega_00", MATRIZ_W'(elem(0, 0)), MATRIZ_W'(9));
`ifdef MATRIZ_COLUNA_EN
        chk("cons_carrega_01", MATRIZ_W'(elem(0, 1)), MATRIZ_W'(7));
        chk("cons_carrega_10", MATRIZ_W'(elem(1, 0)), MATRIZ_W'(8));
`else
        chk("cons_carrega_01", MATRIZ_W'(elem(0, 1)), MATRIZ_W'(8));
        chk("cons_carrega_10", MATRIZ_W'(elem(1, 0)), MATRIZ_W'(7));
`endif
        chk("cons_carrega_11", MATRIZ_W'(elem(1, 1)), MATRIZ_W'(6));
        bus.consumido = 1'b1;
        passo;
        bus.consumido = 1'b0;
        chk("cons_fim_valida", MATRIZ_W'(bus.matriz_valida), '0);

        // Reset after 10 of 25 beats clears everything immediately.
        carrega(5, 1, 1, 1'b0, 10);
        chk("meio_ocupado", MATRIZ_W'(bus.ocupado), MATRIZ_W'(1));
        reset = 1'b1;
        #1;
        chk_zero("reset_meio");
        passo;
        reset = 1'b0;
        passo;

        // Fresh 2x2 load after reset (column order when enabled).
        carrega(2, 1, 1, 1'b0, -1);
        chk("pos_reset_matriz", bus.matriz, modelo);
        chk("pos_reset_00", MATRIZ_W'(elem(0, 0)), MATRIZ_W'(1));
`ifdef MATRIZ_COLUNA_EN
        chk("pos_reset_10", MATRIZ_W'(elem(1, 0)), MATRIZ_W'(2));
        chk("pos_reset_01", MATRIZ_W'(elem(0, 1)), MATRIZ_W'(3));
`else
        chk("pos_reset_01", MATRIZ_W'(elem(0, 1)), MATRIZ_W'(2));
        chk("pos_reset_10", MATRIZ_W'(elem(1, 0)), MATRIZ_W'(3));
`endif
        chk("pos_reset_11", MATRIZ_W'(elem(1, 1)), MATRIZ_W'(4));
        chk("pos_reset_valida", MATRIZ_W'(bus.matriz_valida), MATRIZ_W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
